// File: rtl/hidden_cpu_feeder_if.sv
// Pin bundle between the program feeder and its surroundings: program-load handshake,
// run control, the hidden core's pins and the feeder's status outputs.
// master: host/core side; slave: the feeder.
interface hidden_cpu_feeder_if #(
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [5:0]        load_data;
    logic              start;
    logic              halt_req;
    logic [7:0]        cpu_out;
    logic              cpu_rst;
    logic [5:0]        instr_out;
    logic              busy;
    logic              done;
    logic [1:0]        end_cause;
    logic              r3_valid;
    logic [7:0]        r3_data;

    modport master (
        output load_valid, load_addr, load_data, start, halt_req, cpu_out,
        input  load_ready, cpu_rst, instr_out, busy, done, end_cause, r3_valid, r3_data
    );

    modport slave (
        input  load_valid, load_addr, load_data, start, halt_req, cpu_out,
        output load_ready, cpu_rst, instr_out, busy, done, end_cause, r3_valid, r3_data
    );
endinterface

// File: rtl/hidden_cpu_feeder.sv
// Program feeder / sequencer for the 8-bit hidden CPU core.
// Watches the core output bus (PC or R3), drives the core reset and 6-bit instruction
// field from a loadable program memory, and mirrors the core's output-select toggle.
// Optional build macro FEEDER_CYCLE_LIMIT_EN adds an 8-bit RUN-cycle budget (MAX_CYCLES).
module hidden_cpu_feeder #(
    parameter int unsigned DEPTH       = 32,
    parameter logic [5:0]  NOP_WORD    = 6'b000000,
    parameter logic [5:0]  TOGGLE_WORD = 6'b110000,
    parameter int unsigned MAX_CYCLES  = 255
) (
    input logic                clk,
    input logic                rst,
    hidden_cpu_feeder_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StResetCpu, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic              rcnt_q, rcnt_d;
    logic [5:0]        instr_q, instr_d;
    logic [1:0]        end_cause_q, end_cause_d;
    logic              r3_valid_q, r3_valid_d;
    logic [7:0]        r3_data_q, r3_data_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] shadow_q, shadow_d;
    logic [1:0]        tog_q, tog_d;
    logic [5:0]        mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] fetch_addr;
    logic              out_of_range;

`ifdef FEEDER_CYCLE_LIMIT_EN
    logic [7:0]        cyc_q, cyc_d;
`else
    logic              unused_cfg;
    assign unused_cfg = ^MAX_CYCLES;
`endif

    assign out_of_range = 32'(bus.cpu_out) >= DEPTH;

    // Next-state: sequencing, fetch address, R3 capture and toggle tracking
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        instr_d     = NOP_WORD;
        end_cause_d = end_cause_q;
        r3_valid_d  = 1'b0;
        r3_data_d   = r3_data_q;
        // Core updates its select flag one edge after latching the toggle opcode
        sel_d       = sel_q ^ tog_q[1];
        shadow_d    = shadow_q;
        fetch_addr  = '0;
        mem_we      = 1'b0;
`ifdef FEEDER_CYCLE_LIMIT_EN
        cyc_d       = cyc_q;
`endif

        unique case (state_q)
            StIdle, StDone: begin
                mem_we = bus.load_valid & ~rst;
                if (bus.start) begin
                    state_d     = StResetCpu;
                    rcnt_d      = 1'b0;
                    end_cause_d = 2'b00;
                end
            end
            StResetCpu: begin
                sel_d = 1'b0;
`ifdef FEEDER_CYCLE_LIMIT_EN
                cyc_d = '0;
`endif
                if (bus.halt_req) begin
                    state_d     = StDone;
                    end_cause_d = 2'b10;
                end else if (rcnt_q) begin
                    state_d = StRun;
                end else begin
                    rcnt_d = 1'b1;
                end
            end
            StRun: begin
                if (sel_q) begin
                    // R3 on the bus: PC is invisible, so assume straight-line execution
                    r3_valid_d = 1'b1;
                    r3_data_d  = bus.cpu_out;
                    fetch_addr = (shadow_q == ADDR_W'(DEPTH - 1)) ? '0
                                                                    : shadow_q + ADDR_W'(1);
                end else begin
                    fetch_addr = bus.cpu_out[ADDR_W-1:0];
                end
                shadow_d = fetch_addr;
`ifdef FEEDER_CYCLE_LIMIT_EN
                cyc_d = cyc_q + 8'd1;
`endif
                if (bus.halt_req) begin
                    state_d     = StDone;
                    end_cause_d = 2'b10;
                end else if (!sel_q && out_of_range) begin
                    state_d     = StDone;
                    end_cause_d = 2'b01;
`ifdef FEEDER_CYCLE_LIMIT_EN
                end else if (cyc_q == 8'(MAX_CYCLES - 1)) begin
                    state_d     = StDone;
                    end_cause_d = 2'b11;
`endif
                end else begin
                    instr_d = mem_q[fetch_addr];
                end
            end
            default: state_d = StIdle;
        endcase

        tog_d = (state_q == StResetCpu) ? 2'b00 : {tog_q[0], instr_d == TOGGLE_WORD};
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rcnt_q      <= 1'b0;
            instr_q     <= NOP_WORD;
            end_cause_q <= 2'b00;
            r3_valid_q  <= 1'b0;
            r3_data_q   <= 8'h00;
            sel_q       <= 1'b0;
            shadow_q    <= '0;
            tog_q       <= 2'b00;
`ifdef FEEDER_CYCLE_LIMIT_EN
            cyc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            instr_q     <= instr_d;
            end_cause_q <= end_cause_d;
            r3_valid_q  <= r3_valid_d;
            r3_data_q   <= r3_data_d;
            sel_q       <= sel_d;
            shadow_q    <= shadow_d;
            tog_q       <= tog_d;
`ifdef FEEDER_CYCLE_LIMIT_EN
            cyc_q       <= cyc_d;
`endif
        end
    end

    // Program memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.load_ready = (state_q == StIdle) || (state_q == StDone);
    assign bus.cpu_rst    = (state_q != StRun);
    assign bus.busy       = (state_q == StResetCpu) || (state_q == StRun);
    assign bus.done       = (state_q == StDone);
    assign bus.instr_out  = instr_q;
    assign bus.end_cause  = end_cause_q;
    assign bus.r3_valid   = r3_valid_q;
    assign bus.r3_data    = r3_data_q;
endmodule

// File: tb/tb_hidden_cpu_feeder.sv
// Self-checking bench for hidden_cpu_feeder: directed scenarios followed by randomized
// runs, all compared every cycle against a behavioural model of the feeder.
// Honours FEEDER_CYCLE_LIMIT_EN in the same way as the design.
module tb_hidden_cpu_feeder;
    localparam int unsigned DEPTH       = 32;
    localparam logic [5:0]  NOP_WORD    = 6'b000000;
    localparam logic [5:0]  TOGGLE_WORD = 6'b110000;
    localparam int unsigned MAX_CYCLES  = 8;
`ifdef FEEDER_CYCLE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hidden_cpu_feeder_if #(.DEPTH(DEPTH)) bus ();

    hidden_cpu_feeder #(
        .DEPTH      (DEPTH),
        .NOP_WORD   (NOP_WORD),
        .TOGGLE_WORD(TOGGLE_WORD),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    typedef enum int {MIdle, MReset, MRun, MDone} mphase_e;
    mphase_e    m_phase = MIdle;
    int         m_rc = 0;
    int         m_run_cycles = 0;
    logic [5:0] m_mem [DEPTH];
    logic [5:0] m_instr = NOP_WORD;
    logic [1:0] m_end = 2'b00;
    logic [7:0] m_r3 = 8'h00;
    logic       m_r3v = 1'b0;
    bit         m_sel = 1'b0;
    int         m_shadow = 0;
    int         toggle_edges[$];
    int         edge_n = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        bit         old_sel;
        bit         new_sel;
        int         addr;
        logic [5:0] new_instr;
        edge_n++;
        old_sel = m_sel;
        new_sel = m_sel;
        // The core flips its select flag two edges after the toggle word was issued
        if (toggle_edges.size() > 0 && toggle_edges[0] + 2 == edge_n) begin
            new_sel = !new_sel;
            void'(toggle_edges.pop_front());
        end
        if (rst) begin
            m_phase  = MIdle;
            m_instr  = NOP_WORD;
            m_end    = 2'b00;
            m_r3     = 8'h00;
            m_r3v    = 1'b0;
            m_sel    = 1'b0;
            m_shadow = 0;
            toggle_edges.delete();
            return;
        end
        new_instr = NOP_WORD;
        m_r3v     = 1'b0;
        case (m_phase)
            MIdle, MDone: begin
                if (bus.load_valid) m_mem[bus.load_addr] = bus.load_data;
                if (bus.start) begin
                    m_phase = MReset;
                    m_rc    = 0;
                    m_end   = 2'b00;
                end
            end
            MReset: begin
                new_sel = 1'b0;
                toggle_edges.delete();
                if (bus.halt_req) begin
                    m_phase = MDone;
                    m_end   = 2'b10;
                end else if (m_rc == 1) begin
                    m_phase      = MRun;
                    m_run_cycles = 0;
                end else begin
                    m_rc = 1;
                end
            end
            MRun: begin
                if (old_sel) begin
                    m_r3  = bus.cpu_out;
                    m_r3v = 1'b1;
                    addr  = (m_shadow + 1) % DEPTH;
                end else begin
                    addr = int'(bus.cpu_out) % DEPTH;
                end
                m_shadow = addr;
                m_run_cycles++;
                if (bus.halt_req) begin
                    m_phase = MDone;
                    m_end   = 2'b10;
                end else if (!old_sel && int'(bus.cpu_out) >= DEPTH) begin
                    m_phase = MDone;
                    m_end   = 2'b01;
                end else if (LIMIT_EN && m_run_cycles == MAX_CYCLES) begin
                    m_phase = MDone;
                    m_end   = 2'b11;
                end else begin
                    new_instr = m_mem[addr];
                end
            end
            default: m_phase = MIdle;
        endcase
        m_instr = new_instr;
        if (new_instr == TOGGLE_WORD) toggle_edges.push_back(edge_n);
        m_sel = new_sel;
    endtask

    // One cycle: drive inputs, update the model, clock, compare all outputs
    task automatic step(input bit lv, input int la, input logic [5:0] ld, input bit st,
                        input bit hr, input logic [7:0] co, input bit r);
        bus.load_valid = lv;
        bus.load_addr  = 5'(la);
        bus.load_data  = ld;
        bus.start      = st;
        bus.halt_req   = hr;
        bus.cpu_out    = co;
        rst            = r;
        model_edge();
        @(posedge clk);
        #1;
        check("load_ready", 8'(bus.load_ready), 8'(m_phase == MIdle || m_phase == MDone));
        check("cpu_rst",    8'(bus.cpu_rst),    8'(m_phase != MRun));
        check("busy",       8'(bus.busy),       8'(m_phase == MReset || m_phase == MRun));
        check("done",       8'(bus.done),       8'(m_phase == MDone));
        check("instr_out",  8'(bus.instr_out),  8'(m_instr));
        check("end_cause",  8'(bus.end_cause),  8'(m_end));
        check("r3_valid",   8'(bus.r3_valid),   8'(m_r3v));
        check("r3_data",    bus.r3_data,        m_r3);
        @(negedge clk);
    endtask

    task automatic run_pc(input logic [7:0] co);
        step(1'b0, 0, 6'h00, 1'b0, 1'b0, co, 1'b0);
    endtask

    task automatic start_run();
        step(1'b0, 0, 6'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        run_pc(8'h00);
        run_pc(8'h00);
    endtask

    task automatic load(input int a, input logic [5:0] d);
        step(1'b1, a, d, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [5:0] w;
        int         r;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.start      = 1'b0;
        bus.halt_req   = 1'b0;
        bus.cpu_out    = '0;
        rst            = 1'b1;

        // Reset state
        step(1'b0, 0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 0, 6'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_load_ready", 8'(bus.load_ready), 8'h01);
        check("rst_cpu_rst",    8'(bus.cpu_rst),    8'h01);
        check("rst_instr",      8'(bus.instr_out),  8'(NOP_WORD));
        run_pc(8'h00);

        // Load and run: PC 0,1,2 then out of range
        for (int i = 0; i < DEPTH; i++) begin
            w = 6'($urandom);
            if (w == TOGGLE_WORD) w = 6'h01;
            load(i, w);
        end
        load(0, 6'h11);
        load(1, 6'h22);
        load(2, 6'h0F);
        start_run();
        check("busy_in_run", 8'(bus.busy), 8'h01);
        run_pc(8'd0);
        check("run_mem0", 8'(bus.instr_out), 8'h11);
        run_pc(8'd1);
        check("run_mem1", 8'(bus.instr_out), 8'h22);
        run_pc(8'd2);
        check("run_mem2", 8'(bus.instr_out), 8'h0F);
        run_pc(8'd40);
        check("range_done",  8'(bus.done),      8'h01);
        check("range_cause", 8'(bus.end_cause), 8'h01);
        check("range_rst",   8'(bus.cpu_rst),   8'h01);

        // Toggle into R3 view, capture, shadow address advances
        load(1, TOGGLE_WORD);
        start_run();
        run_pc(8'd0);
        run_pc(8'd1);
        check("toggle_issued", 8'(bus.instr_out), 8'(TOGGLE_WORD));
        run_pc(8'd2);
        run_pc(8'd3);
        check("pre_r3_valid", 8'(bus.r3_valid), 8'h00);
        run_pc(8'h5A);
        check("r3_valid", 8'(bus.r3_valid), 8'h01);
        check("r3_data",  bus.r3_data,      8'h5A);
        check("r3_fetch4", 8'(bus.instr_out), 8'(m_mem[4]));
        run_pc(8'h33);
        check("r3_fetch5", 8'(bus.instr_out), 8'(m_mem[5]));
        step(1'b0, 0, 6'h00, 1'b0, 1'b1, 8'd40, 1'b0);
        check("r3_halt_cause", 8'(bus.end_cause), 8'h02);

        // Halt beats PC out of range in the same cycle
        start_run();
        run_pc(8'd0);
        step(1'b0, 0, 6'h00, 1'b0, 1'b1, 8'd40, 1'b0);
        check("halt_cause", 8'(bus.end_cause), 8'h02);
        check("halt_nop",   8'(bus.instr_out), 8'(NOP_WORD));

        // Load and start in the same cycle
        step(1'b1, 0, 6'h2D, 1'b1, 1'b0, 8'h00, 1'b0);
        check("coll_ready", 8'(bus.load_ready), 8'h00);
        run_pc(8'h00);
        run_pc(8'h00);
        run_pc(8'd0);
        check("coll_fetch", 8'(bus.instr_out), 8'h2D);
        run_pc(8'd40);

        // Cycle budget with PC parked at 0
        start_run();
        for (int i = 0; i < MAX_CYCLES + 2; i++) run_pc(8'd0);
        check("limit_done",  8'(bus.done),      8'(LIMIT_EN));
        check("limit_cause", 8'(bus.end_cause), LIMIT_EN ? 8'h03 : 8'h00);
        step(1'b0, 0, 6'h00, 1'b0, 1'b1, 8'd0, 1'b0);

        // Reset in the middle of a run
        start_run();
        run_pc(8'd0);
        run_pc(8'd1);
        step(1'b0, 0, 6'h00, 1'b0, 1'b0, 8'd2, 1'b1);
        check("mid_rst_ready", 8'(bus.load_ready), 8'h01);
        check("mid_rst_instr", 8'(bus.instr_out),  8'(NOP_WORD));
        check("mid_rst_r3",    bus.r3_data,        8'h00);
        check("mid_rst_busy",  8'(bus.busy),       8'h00);
        run_pc(8'd0);
        start_run();
        run_pc(8'd0);
        check("rerun_mem0", 8'(bus.instr_out), 8'h2D);
        run_pc(8'd40);

        // Randomized runs over a program that contains toggle words
        for (int i = 0; i < DEPTH; i++) begin
            w = ($urandom_range(0, 3) == 0) ? TOGGLE_WORD : 6'($urandom);
            load(i, w);
        end
        for (int run = 0; run < 25; run++) begin
            start_run();
            for (int c = 0; c < 50; c++) begin
                r = int'($urandom_range(0, 99));
                step($urandom_range(0, 4) == 0, int'($urandom_range(0, DEPTH - 1)),
                     6'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0,
                     (r < 5) ? 8'($urandom_range(DEPTH, 255)) : 8'($urandom_range(0, DEPTH - 1)),
                     $urandom_range(0, 99) == 0);
                if (m_phase == MIdle || m_phase == MDone) break;
            end
            for (int c = 0; c < 3; c++) begin
                w = ($urandom_range(0, 3) == 0) ? TOGGLE_WORD : 6'($urandom);
                step($urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)), w, 1'b0,
                     1'b0, 8'($urandom), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
